// File: rtl/uart_protocol_wide.sv
// ---------------------------------------------------------------------------
// uart_protocol_wide
//
// Bridges an ASCII command stream from a UART core to a parallel bus master
// port, with generic address/data widths, burst reads, a bus ack timeout
// that is reported over UART, and a debug system-reset pulse.
//
// Command set (received bytes):
//   'L'        enter address mode, nibble count 0
//   'W'        enter write mode, nibble count 0
//   'R'        read one word at the current address
//   'N' h h    read 0xhh words (00 means 256)
//   '*'        one-cycle system reset pulse
//   hex digit  address nibble or write-data nibble depending on mode
//
// Ports:
//   i_clk, i_reset            clock, asynchronous active-high reset
//   i_ack, i_dat              bus ack and read data (valid with ack)
//   o_dat, o_addr, o_we, o_cs bus master outputs; o_cs held until ack/timeout
//   i_uart_received_pulse     1-cycle strobe qualifying i_uart_dat
//   i_uart_dat                received ASCII byte
//   i_uart_send_ready         tx can accept a byte this cycle
//   o_uart_send_pulse         tx strobe (combinational)
//   o_uart_dat                tx ASCII byte, valid with o_uart_send_pulse
//   o_reset                   registered 1-cycle system reset pulse
// ---------------------------------------------------------------------------
module uart_protocol_wide #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_ack,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_dat,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_we,
    output logic              o_cs,
    input  logic              i_uart_received_pulse,
    input  logic [7:0]        i_uart_dat,
    input  logic              i_uart_send_ready,
    output logic              o_uart_send_pulse,
    output logic [7:0]        o_uart_dat,
    output logic              o_reset
);

    localparam int unsigned AddrNib = ADDR_W / 4;
    localparam int unsigned DataNib = DATA_W / 4;
    localparam int unsigned MaxNib  = (AddrNib > DataNib) ? AddrNib : DataNib;
    localparam int unsigned NibW    = $clog2(MaxNib + 1);
    localparam int unsigned SendW   = $clog2(DataNib + 1);
    localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StBusW,
        StBusR,
        StSend,
        StErr
    } state_e;

    typedef enum logic {
        ModeAddr,
        ModeWrite
    } mode_e;

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    state_e            r_state;
    mode_e             r_mode;
    logic [NibW-1:0]   r_nib_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdat;
    logic [DATA_W-1:0] r_shift;     // read word, shifted left as chars go out
    logic [SendW-1:0]  r_send_cnt;
    logic [8:0]        r_burst;     // words left in the current read burst
    logic [1:0]        r_n_cnt;     // 0: no 'N' pending, 1/2: awaiting hex 1/2
    logic [3:0]        r_n_hi;
    logic [TmoW-1:0]   r_tmo;
    logic              r_reset;

    // ---------------------------------------------------------------------
    // Wires
    // ---------------------------------------------------------------------
    state_e            w_state_next;
    logic              w_is_hex;
    logic [3:0]        w_nib;
    logic              w_rx_idle;
    logic              w_cmd_l;
    logic              w_cmd_w;
    logic              w_cmd_r;
    logic              w_cmd_n;
    logic              w_cmd_star;
    logic              w_hex_rx;
    logic              w_n_done;
    logic [7:0]        w_n_val;
    logic              w_start_write;
    logic              w_start_read;
    logic              w_bus;
    logic              w_tmo_hit;
    logic              w_last_char;
    logic              w_tx_fire;

    // ---------------------------------------------------------------------
    // Hex decode of the received byte (either case)
    // ---------------------------------------------------------------------
    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'h0;
        if (i_uart_dat >= 8'h30 && i_uart_dat <= 8'h39) begin
            w_nib = i_uart_dat[3:0];
        end else if ((i_uart_dat >= 8'h61 && i_uart_dat <= 8'h66) ||
                     (i_uart_dat >= 8'h41 && i_uart_dat <= 8'h46)) begin
            // 'a'/'A' have low nibble 1, so +9 maps them to 10
            w_nib = i_uart_dat[3:0] + 4'd9;
        end else begin
            w_is_hex = 1'b0;
        end
    end

    // Everything except '*' is dropped unless the FSM is idle.
    assign w_rx_idle  = i_uart_received_pulse && (r_state == StIdle);
    assign w_cmd_l    = w_rx_idle && (i_uart_dat == 8'h4c);
    assign w_cmd_w    = w_rx_idle && (i_uart_dat == 8'h57);
    assign w_cmd_r    = w_rx_idle && (i_uart_dat == 8'h52);
    assign w_cmd_n    = w_rx_idle && (i_uart_dat == 8'h4e);
    assign w_cmd_star = i_uart_received_pulse && (i_uart_dat == 8'h2a);
    assign w_hex_rx   = w_rx_idle && w_is_hex;

    assign w_n_done      = w_hex_rx && (r_n_cnt == 2'd2);
    assign w_n_val       = {r_n_hi, w_nib};
    assign w_start_write = w_hex_rx && (r_n_cnt == 2'd0) && (r_mode == ModeWrite) &&
                           (r_nib_cnt == NibW'(DataNib - 1));
    assign w_start_read  = w_cmd_r || w_n_done;

    assign w_bus       = (r_state == StBusW) || (r_state == StBusR);
    // A same-cycle ack takes priority over the timeout.
    assign w_tmo_hit   = (r_tmo == TmoW'(TIMEOUT - 1)) && !i_ack;
    assign w_last_char = (r_send_cnt == SendW'(DataNib - 1));
    assign w_tx_fire   = o_uart_send_pulse;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start_write) begin
                    w_state_next = StBusW;
                end else if (w_start_read) begin
                    w_state_next = StBusR;
                end
            end
            StBusW: begin
                if (i_ack) begin
                    w_state_next = StIdle;
                end else if (w_tmo_hit) begin
                    w_state_next = StErr;
                end
            end
            StBusR: begin
                if (i_ack) begin
                    w_state_next = StSend;
                end else if (w_tmo_hit) begin
                    w_state_next = StErr;
                end
            end
            StSend: begin
                if (w_tx_fire && w_last_char) begin
                    w_state_next = (r_burst > 9'd1) ? StBusR : StIdle;
                end
            end
            StErr: begin
                if (w_tx_fire) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    always_comb begin
        o_cs              = w_bus;
        o_we              = (r_state == StBusW);
        o_addr            = r_addr;
        o_dat             = r_wdat;
        o_reset           = r_reset;
        o_uart_send_pulse = 1'b0;
        o_uart_dat        = 8'h00;
        if (r_state == StSend) begin
            o_uart_send_pulse = i_uart_send_ready;
            o_uart_dat        = hex_char(r_shift[DATA_W-1 -: 4]);
        end else if (r_state == StErr) begin
            o_uart_send_pulse = i_uart_send_ready;
            o_uart_dat        = 8'h21;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mode     <= ModeAddr;
            r_nib_cnt  <= '0;
            r_addr     <= '0;
            r_wdat     <= '0;
            r_shift    <= '0;
            r_send_cnt <= '0;
            r_burst    <= '0;
            r_n_cnt    <= 2'd0;
            r_n_hi     <= 4'h0;
            r_tmo      <= '0;
            r_reset    <= 1'b0;
        end else begin
            // A '*' seen while the pulse is already high is swallowed.
            r_reset <= w_cmd_star && !r_reset;

            if (w_cmd_l) begin
                r_mode    <= ModeAddr;
                r_nib_cnt <= '0;
                r_n_cnt   <= 2'd0;
            end
            if (w_cmd_w) begin
                r_mode    <= ModeWrite;
                r_nib_cnt <= '0;
                r_n_cnt   <= 2'd0;
            end
            if (w_cmd_r) begin
                r_n_cnt <= 2'd0;
                r_burst <= 9'd1;
            end
            if (w_cmd_n) begin
                r_n_cnt <= 2'd1;
            end

            if (w_hex_rx) begin
                if (r_n_cnt == 2'd1) begin
                    r_n_hi  <= w_nib;
                    r_n_cnt <= 2'd2;
                end else if (r_n_cnt == 2'd2) begin
                    r_n_cnt <= 2'd0;
                    r_burst <= (w_n_val == 8'h00) ? 9'd256 : {1'b0, w_n_val};
                end else if (r_mode == ModeAddr) begin
                    // Surplus address nibbles are ignored and not counted.
                    if (r_nib_cnt < NibW'(AddrNib)) begin
                        for (int unsigned k = 0; k < AddrNib; k++) begin
                            if (r_nib_cnt == NibW'(k)) begin
                                r_addr[ADDR_W-1-4*k -: 4] <= w_nib;
                            end
                        end
                        r_nib_cnt <= r_nib_cnt + NibW'(1);
                    end
                end else begin
                    for (int unsigned k = 0; k < DataNib; k++) begin
                        if (r_nib_cnt == NibW'(k)) begin
                            r_wdat[DATA_W-1-4*k -: 4] <= w_nib;
                        end
                    end
                    // Wrap so back-to-back words need no new 'W'.
                    r_nib_cnt <= (r_nib_cnt == NibW'(DataNib - 1)) ? '0
                                                                   : r_nib_cnt + NibW'(1);
                end
            end

            // Cleared outside bus states, so every bus entry starts at 0.
            r_tmo <= w_bus ? r_tmo + TmoW'(1) : '0;

            if (w_bus && i_ack) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            if (r_state == StBusR && i_ack) begin
                r_shift    <= i_dat;
                r_send_cnt <= '0;
            end

            if (r_state == StSend && w_tx_fire) begin
                r_shift <= r_shift << 4;
                if (w_last_char) begin
                    r_send_cnt <= '0;
                    r_burst    <= (r_burst > 9'd1) ? r_burst - 9'd1 : 9'd0;
                end else begin
                    r_send_cnt <= r_send_cnt + SendW'(1);
                end
            end

            if (r_state == StErr && w_tx_fire) begin
                r_burst <= 9'd0;
            end
        end
    end

endmodule

// File: tb/tb_uart_protocol_wide.sv
module tb_uart_protocol_wide;

    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned TMO = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ack = 1'b0;
    logic [DW-1:0] bus_rdat = '0;
    logic [DW-1:0] bus_wdat;
    logic [AW-1:0] bus_addr;
    logic          bus_we;
    logic          bus_cs;
    logic          rx_pulse = 1'b0;
    logic [7:0]    rx_dat = 8'h00;
    logic          tx_ready = 1'b1;
    logic          tx_pulse;
    logic [7:0]    tx_dat;
    logic          sys_reset;

    always #5 clk = ~clk;

    uart_protocol_wide #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .i_clk                (clk),
        .i_reset              (rst),
        .i_ack                (ack),
        .i_dat                (bus_rdat),
        .o_dat                (bus_wdat),
        .o_addr               (bus_addr),
        .o_we                 (bus_we),
        .o_cs                 (bus_cs),
        .i_uart_received_pulse(rx_pulse),
        .i_uart_dat           (rx_dat),
        .i_uart_send_ready    (tx_ready),
        .o_uart_send_pulse    (tx_pulse),
        .o_uart_dat           (tx_dat),
        .o_reset              (sys_reset)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] tx_q[$];
    always @(negedge clk) if (tx_pulse) tx_q.push_back(tx_dat);

    typedef struct {
        logic [7:0]  rx;
        logic        cs;
        logic        we;
        logic [15:0] addr;
        logic [15:0] dat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] rx, input logic cs, input logic we,
                                input logic [15:0] addr, input logic [15:0] dat);
        vec_t v;
        v.rx   = rx;
        v.cs   = cs;
        v.we   = we;
        v.addr = addr;
        v.dat  = dat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_pulse = 1'b1;
        rx_dat   = b;
        @(posedge clk);
        #1;
        rx_pulse = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic pulse_ack(input logic [DW-1:0] d);
        bus_rdat = d;
        ack      = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic wait_cs(input string name, input int budget);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus_cs && w < budget);
        chk(name, {31'd0, bus_cs}, 32'd1);
    endtask

    task automatic check_tx(input string name, input string exp, input int budget);
        int    w = 0;
        string act = "";
        while (tx_q.size() < exp.len() && w < budget) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < tx_q.size(); i++) act = $sformatf("%s%c", act, tx_q[i]);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: tx got \"%s\", expected \"%s\"", name, act, exp);
        end
        tx_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] burst_addr[3];
        int          cnt;
        burst_addr[0] = 16'hfffe;
        burst_addr[1] = 16'hffff;
        burst_addr[2] = 16'h0000;

        // Address entry (with a junk byte and a surplus nibble), then one write word.
        vecs.push_back(mk("L", 1'b0, 1'b0, 16'h0000, 16'h0000));
        vecs.push_back(mk("1", 1'b0, 1'b0, 16'h1000, 16'h0000));
        vecs.push_back(mk("A", 1'b0, 1'b0, 16'h1a00, 16'h0000));
        vecs.push_back(mk("x", 1'b0, 1'b0, 16'h1a00, 16'h0000));
        vecs.push_back(mk("2", 1'b0, 1'b0, 16'h1a20, 16'h0000));
        vecs.push_back(mk("b", 1'b0, 1'b0, 16'h1a2b, 16'h0000));
        vecs.push_back(mk("5", 1'b0, 1'b0, 16'h1a2b, 16'h0000));
        vecs.push_back(mk("W", 1'b0, 1'b0, 16'h1a2b, 16'h0000));
        vecs.push_back(mk("1", 1'b0, 1'b0, 16'h1a2b, 16'h1000));
        vecs.push_back(mk("2", 1'b0, 1'b0, 16'h1a2b, 16'h1200));
        vecs.push_back(mk("3", 1'b0, 1'b0, 16'h1a2b, 16'h1230));
        vecs.push_back(mk("4", 1'b1, 1'b1, 16'h1a2b, 16'h1234));

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_cs", {31'd0, bus_cs}, 32'd0);
        chk("rst_we", {31'd0, bus_we}, 32'd0);
        chk("rst_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_dat", {16'd0, bus_wdat}, 32'd0);
        chk("rst_oreset", {31'd0, sys_reset}, 32'd0);
        chk("rst_txpulse", {31'd0, tx_pulse}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            send_byte(vecs[i].rx);
            @(negedge clk);
            chk($sformatf("vec%0d_cs", i), {31'd0, bus_cs}, {31'd0, vecs[i].cs});
            chk($sformatf("vec%0d_we", i), {31'd0, bus_we}, {31'd0, vecs[i].we});
            chk($sformatf("vec%0d_addr", i), {16'd0, bus_addr}, {16'd0, vecs[i].addr});
            chk($sformatf("vec%0d_dat", i), {16'd0, bus_wdat}, {16'd0, vecs[i].dat});
        end

        // First write acked in its first cycle
        pulse_ack('0);
        @(negedge clk);
        chk("w1_cs_drop", {31'd0, bus_cs}, 32'd0);
        chk("w1_addr_inc", {16'd0, bus_addr}, 32'h1a2c);

        // Second word without a new 'W', ack delayed 3 cycles
        send_str("5678");
        @(negedge clk);
        chk("w2_cs", {31'd0, bus_cs}, 32'd1);
        chk("w2_we", {31'd0, bus_we}, 32'd1);
        chk("w2_addr", {16'd0, bus_addr}, 32'h1a2c);
        chk("w2_dat", {16'd0, bus_wdat}, 32'h5678);
        repeat (3) begin
            @(negedge clk);
            chk("w2_cs_hold", {31'd0, bus_cs}, 32'd1);
        end
        pulse_ack('0);
        @(negedge clk);
        chk("w2_cs_drop", {31'd0, bus_cs}, 32'd0);
        chk("w2_addr_inc", {16'd0, bus_addr}, 32'h1a2d);

        // Single read
        send_str("L00ffR");
        @(negedge clk);
        chk("r_cs", {31'd0, bus_cs}, 32'd1);
        chk("r_we", {31'd0, bus_we}, 32'd0);
        chk("r_addr", {16'd0, bus_addr}, 32'h00ff);
        pulse_ack(16'hbeef);
        check_tx("r_tx", "beef", 30);
        chk("r_addr_after", {16'd0, bus_addr}, 32'h0100);
        chk("r_idle_cs", {31'd0, bus_cs}, 32'd0);

        // Burst of 3 across the address wrap
        send_str("Lfffe");
        send_str("N03");
        for (int i = 0; i < 3; i++) begin
            wait_cs($sformatf("burst%0d_cs", i), 40);
            chk($sformatf("burst%0d_addr", i), {16'd0, bus_addr}, {16'd0, burst_addr[i]});
            pulse_ack(DW'(i + 1));
        end
        check_tx("burst_tx", "000100020003", 60);
        chk("burst_addr_after", {16'd0, bus_addr}, 32'h0001);

        // Timeout with no ack
        send_str("L0010R");
        cnt = 0;
        @(negedge clk);
        while (bus_cs && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_cycles", cnt, TMO);
        check_tx("tmo_tx", "!", 10);
        chk("tmo_addr", {16'd0, bus_addr}, 32'h0010);

        // Ack in the very cycle the timeout would fire: ack wins
        send_str("L0020R");
        @(negedge clk);
        repeat (TMO - 1) @(negedge clk);
        chk("lateack_cs", {31'd0, bus_cs}, 32'd1);
        pulse_ack(16'h0a0b);
        check_tx("lateack_tx", "0a0b", 30);
        chk("lateack_addr", {16'd0, bus_addr}, 32'h0021);

        // '*' during a stalled SEND; a second '*' while o_reset is high is ignored
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        send_byte("R");
        @(negedge clk);
        chk("star_cs", {31'd0, bus_cs}, 32'd1);
        bus_rdat = 16'hc0de;
        ack      = 1'b1;
        @(posedge clk);
        #1;
        ack      = 1'b0;
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        rx_pulse = 1'b1;
        rx_dat   = "*";
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("star_reset_hi", {31'd0, sys_reset}, 32'd1);
        @(posedge clk);
        #1;
        rx_pulse = 1'b0;
        @(negedge clk);
        chk("star_reset_lo", {31'd0, sys_reset}, 32'd0);
        repeat (2) @(negedge clk);
        chk("star_stalled", tx_q.size(), 32'd1);
        tx_ready = 1'b1;
        check_tx("star_tx", "c0de", 20);
        chk("star_addr", {16'd0, bus_addr}, 32'h0022);

        // Async reset in the middle of a bus read
        send_str("WR");
        @(negedge clk);
        chk("mrst_cs_before", {31'd0, bus_cs}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_cs", {31'd0, bus_cs}, 32'd0);
        chk("mrst_addr", {16'd0, bus_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("mrst_no_tx", tx_q.size(), 32'd0);
        chk("mrst_oreset", {31'd0, sys_reset}, 32'd0);
        send_str("12");
        @(negedge clk);
        chk("mrst_mode_addr", {16'd0, bus_addr}, 32'h1200);
        chk("mrst_dat", {16'd0, bus_wdat}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
